imem_sync: RTL

IMEM_SYNC -- requirements
Module: imem_sync

---
 rtl/imem_pkg.sv | 10 +
 rtl/imem_sync_if.sv | 28 ++
 rtl/imem_array.sv | 21 ++
 rtl/imem_sync.sv | 53 +++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and the response record for imem_sync
package imem_pkg;
    localparam int DEPTH_DEF = 2048;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } rsp_t;
endpackage

// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch request/response handshake plus program-load port
//   slave  (memory side): takes requests, program writes, rsp_ready/flush; drives ready and response
//   master (fetch side) : the mirror image
interface imem_sync_if import imem_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = $clog2(DEPTH);
    logic          i_req_valid;
    logic          o_req_ready;
    logic [31:0]   i_pc;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc;
    logic          o_fault;
    logic          i_flush;
    logic          i_prog_we;
    logic [AW-1:0] i_prog_addr;
    logic [31:0]   i_prog_data;
    modport slave (
        input  i_req_valid, i_pc, i_rsp_ready, i_flush, i_prog_we, i_prog_addr, i_prog_data,
        output o_req_ready, o_rsp_valid, o_instr, o_pc, o_fault
    );
    modport master (
        output i_req_valid, i_pc, i_rsp_ready, i_flush, i_prog_we, i_prog_addr, i_prog_data,
        input  o_req_ready, o_rsp_valid, o_instr, o_pc, o_fault
    );
endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 storage, one sync write port and one enabled sync read port, no reset
//   clk: clock; we/waddr/wdata: write port; re/raddr: read enable/address; rdata: registered read data
module imem_array #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    // Read data only moves on an enabled read, so it doubles as the held response word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/imem_sync.sv
// imem_sync: 1-cycle instruction fetch memory with valid/ready handshake, fault detection and program load
//   i_clk/i_reset: clock and async active-high reset
//   bus (slave): request (valid/ready/pc), response (valid/ready/instr/pc/fault), flush, program write
module imem_sync import imem_pkg::*; #(
    parameter int          DEPTH = DEPTH_DEF,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input logic        i_clk,
    input logic        i_reset,
    imem_sync_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
    logic        accept;
    logic        bad;
    logic        rsp_valid;
    logic        fault_q;
    logic [31:0] pc_q;
    logic [31:0] rdata;
    rsp_t        rsp;
    // Program writes stall requests, so the array never sees a read and write together.
    assign bus.o_req_ready = !bus.i_prog_we && !bus.i_flush && (!rsp_valid || bus.i_rsp_ready);
    assign accept = bus.i_req_valid && bus.o_req_ready;
    assign bad = (bus.i_pc[1:0] != 2'b00) || (bus.i_pc >= LIMIT);
    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (i_clk),
        .we    (bus.i_prog_we),
        .waddr (bus.i_prog_addr),
        .wdata (bus.i_prog_data),
        .re    (accept),
        .raddr (bus.i_pc[AW+1:2]),
        .rdata (rdata)
    );
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_valid <= 1'b0;
            pc_q      <= '0;
            fault_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            pc_q      <= bus.i_pc;
            fault_q   <= bad;
        end else if (bus.i_flush || bus.i_rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
    // Array data is unreset, so NOP is substituted whenever no good response is held.
    always_comb rsp = '{instr: (rsp_valid && !fault_q) ? rdata : NOP, pc: pc_q, fault: fault_q};
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_instr     = rsp.instr;
    assign bus.o_pc        = rsp.pc;
    assign bus.o_fault     = rsp.fault;
endmodule
